// File: rtl/hls_kernel_pkg.sv
// Shared definitions for the HLS-style dot-product kernel: FSM state encoding
// and the default geometry used by the kernel, its interface and its multiplier.
package hls_kernel_pkg;
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_MUL_LAT = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_MUL,
    S_ACC,
    S_DONE
  } state_t;
endpackage

// File: rtl/hls_dot_kernel_if.sv
// Control, operand-write and result bundle of hls_dot_kernel.
interface hls_dot_kernel_if
  import hls_kernel_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  logic                     start;
  logic [$clog2(DEPTH):0]   len;
  logic                     wr_en;
  logic                     wr_sel;
  logic [$clog2(DEPTH)-1:0] wr_addr;
  logic [WIDTH-1:0]         wr_data;
  logic                     busy;
  logic                     finished;
  logic [WIDTH-1:0]         return_val;

  modport master (
    output start, len, wr_en, wr_sel, wr_addr, wr_data,
    input  busy, finished, return_val
  );

  modport slave (
    input  start, len, wr_en, wr_sel, wr_addr, wr_data,
    output busy, finished, return_val
  );
endinterface

// File: rtl/hls_pipe_mul.sv
// Pipelined unsigned multiplier: WIDTH-bit truncated product appears exactly
// MUL_LAT cycles after the operands are presented.
module hls_pipe_mul
  import hls_kernel_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_p
);
  logic [MUL_LAT-1:0][WIDTH-1:0] r_p;

  always_ff @(posedge clk) begin
    r_p[0] <= i_a * i_b;
    for (int k = 1; k < MUL_LAT; k++) r_p[k] <= r_p[k-1];
  end

  assign o_p = r_p[MUL_LAT-1];
endmodule

// File: rtl/hls_dot_kernel.sv
// Sequential dot product of two on-chip operand memories, one element per
// READ -> MUL(MUL_LAT) -> ACC round trip.
module hls_dot_kernel
  import hls_kernel_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic             clk,
  input  logic             reset,
  hls_dot_kernel_if.slave  bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;
  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0] MC_LAST = CW'(MUL_LAT - 1);

  state_t           r_state, w_next;
  logic [LW-1:0]    r_n;
  logic [IW-1:0]    r_idx;
  logic [CW-1:0]    r_mcnt;
  logic [WIDTH-1:0] r_acc, r_ret, r_xa, r_ya;
  logic             r_fin;
  logic [WIDTH-1:0] r_mem_x [DEPTH];
  logic [WIDTH-1:0] r_mem_y [DEPTH];

  // A write landing on the launch edge must stay invisible to that run:
  // remember the overwritten word and substitute it on read.
  logic             r_sh_vld, r_sh_sel;
  logic [IW-1:0]    r_sh_addr;
  logic [WIDTH-1:0] r_sh_old;

  logic             w_open, w_last;
  logic [LW-1:0]    w_len_c;
  logic [WIDTH-1:0] w_rx, w_ry, w_prod;

  assign w_open  = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_len_c = (bus.len > LW'(DEPTH)) ? LW'(DEPTH) : bus.len;
  assign w_last  = ({1'b0, r_idx} == (r_n - LW'(1)));

  assign w_rx = (r_sh_vld && !r_sh_sel && r_sh_addr == r_idx) ? r_sh_old : r_mem_x[r_idx];
  assign w_ry = (r_sh_vld &&  r_sh_sel && r_sh_addr == r_idx) ? r_sh_old : r_mem_y[r_idx];

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (bus.start) w_next = (w_len_c != '0) ? S_READ : S_DONE;
      S_READ:         w_next = S_MUL;
      S_MUL:          if (r_mcnt == MC_LAST) w_next = S_ACC;
      S_ACC:          w_next = w_last ? S_DONE : S_READ;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_n      <= '0;
      r_idx    <= '0;
      r_mcnt   <= '0;
      r_acc    <= '0;
      r_ret    <= '0;
      r_fin    <= 1'b0;
      r_sh_vld <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (bus.start) begin
          r_n       <= w_len_c;
          r_idx     <= '0;
          r_acc     <= '0;
          r_fin     <= (w_len_c == '0);
          if (w_len_c == '0) r_ret <= '0;
          r_sh_vld  <= bus.wr_en;
          r_sh_sel  <= bus.wr_sel;
          r_sh_addr <= bus.wr_addr;
          r_sh_old  <= bus.wr_sel ? r_mem_y[bus.wr_addr] : r_mem_x[bus.wr_addr];
        end
        S_READ: begin
          r_xa   <= w_rx;
          r_ya   <= w_ry;
          r_mcnt <= '0;
        end
        S_MUL: r_mcnt <= r_mcnt + CW'(1);
        S_ACC: begin
          r_acc <= r_acc + w_prod;
          if (w_last) begin
            r_ret <= r_acc + w_prod;
            r_fin <= 1'b1;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Operand memories are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!reset && bus.wr_en && w_open) begin
      if (bus.wr_sel) r_mem_y[bus.wr_addr] <= bus.wr_data;
      else            r_mem_x[bus.wr_addr] <= bus.wr_data;
    end
  end

  hls_pipe_mul #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) u_mul (
    .clk (clk),
    .i_a (r_xa),
    .i_b (r_ya),
    .o_p (w_prod)
  );

  assign bus.busy       = (r_state == S_READ) || (r_state == S_MUL) || (r_state == S_ACC);
  assign bus.finished   = r_fin;
  assign bus.return_val = r_ret;
endmodule

// File: tb/tb_hls_dot_kernel.sv
// Randomized self-checking bench for hls_dot_kernel against an array-based
// dot-product model; a second narrow instance covers product truncation.
module tb_hls_dot_kernel;
  localparam int L0 = 2;
  localparam int L1 = 3;

  logic clk = 1'b0;
  logic reset;
  int   errs = 0;
  int   checks = 0;

  logic [31:0] mx [8];
  logic [31:0] my [8];
  logic [7:0]  nx [4];
  logic [7:0]  ny [4];

  hls_dot_kernel_if #(.WIDTH(32), .DEPTH(8)) b0 ();
  hls_dot_kernel_if #(.WIDTH(8),  .DEPTH(4)) b1 ();

  hls_dot_kernel #(.WIDTH(32), .DEPTH(8), .MUL_LAT(L0)) u0 (.clk(clk), .reset(reset), .bus(b0.slave));
  hls_dot_kernel #(.WIDTH(8),  .DEPTH(4), .MUL_LAT(L1)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_dot(input int len);
    logic [31:0] acc = 0;
    int n = (len > 8) ? 8 : len;
    for (int i = 0; i < n; i++) acc = acc + mx[i] * my[i];
    return acc;
  endfunction

  function automatic logic [7:0] ref_dot8(input int len);
    logic [7:0] acc = 0;
    int n = (len > 4) ? 4 : len;
    for (int i = 0; i < n; i++) acc = acc + nx[i] * ny[i];
    return acc;
  endfunction

  task automatic wr(input bit sel, input int addr, input logic [31:0] d);
    b0.wr_en = 1'b1; b0.wr_sel = sel; b0.wr_addr = 3'(addr); b0.wr_data = d;
    @(posedge clk); #1;
    b0.wr_en = 1'b0;
    if (sel) my[addr] = d; else mx[addr] = d;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 8; i++) begin
      wr(1'b0, i, $urandom);
      wr(1'b1, i, $urandom);
    end
  endtask

  task automatic run(input int len, output int cyc, output bit bok);
    b0.start = 1'b1; b0.len = 4'(len);
    @(posedge clk); #1;
    b0.start = 1'b0;
    cyc = 0; bok = 1'b1;
    while (!b0.finished && cyc < 500) begin
      if (!b0.busy) bok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (b0.finished !== 1'b0) begin errs++; $display("FAIL reset_finished got %0b want 0", b0.finished); end
    checks++; if (b0.return_val !== 32'd0) begin errs++; $display("FAIL reset_ret got %0d want 0", b0.return_val); end
    checks++; if (b0.busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %0b want 0", b0.busy); end
    checks++; if (b1.return_val !== 8'd0) begin errs++; $display("FAIL reset_ret8 got %0d want 0", b1.return_val); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int cyc; bit bok;
    wr(1'b0, 0, 32'd2);
    wr(1'b1, 0, 32'd3);
    run(1, cyc, bok);
    checks++; if (cyc !== 4) begin errs++; $display("FAIL single_latency got %0d want 4", cyc); end
    checks++; if (b0.return_val !== 32'd6) begin errs++; $display("FAIL single_ret got %0d want 6", b0.return_val); end
  endtask

  task automatic test_ramp();
    int cyc; bit bok;
    for (int i = 0; i < 8; i++) begin
      wr(1'b0, i, 32'(i + 1));
      wr(1'b1, i, 32'(8 - i));
    end
    run(8, cyc, bok);
    checks++; if (b0.return_val !== 32'd120) begin errs++; $display("FAIL ramp_ret got %0d want 120", b0.return_val); end
    checks++; if (cyc !== 32) begin errs++; $display("FAIL ramp_latency got %0d want 32", cyc); end
    checks++; if (bok !== 1'b1) begin errs++; $display("FAIL ramp_busy got dropped want held"); end
  endtask

  task automatic test_random();
    int cyc, len, n; bit bok; logic [31:0] exp;
    for (int it = 0; it < 6; it++) begin
      fill_rand();
      len = $urandom_range(0, 15);
      n = (len > 8) ? 8 : len;
      exp = ref_dot(len);
      run(len, cyc, bok);
      checks++; if (b0.return_val !== exp) begin errs++; $display("FAIL rand_ret len=%0d got %h want %h", len, b0.return_val, exp); end
      checks++; if (cyc !== n * (L0 + 2)) begin errs++; $display("FAIL rand_latency len=%0d got %0d want %0d", len, cyc, n * (L0 + 2)); end
    end
  endtask

  task automatic test_len_edge();
    int cyc; bit bok; logic [31:0] r8;
    fill_rand();
    run(0, cyc, bok);
    checks++; if (cyc !== 0) begin errs++; $display("FAIL len0_latency got %0d want 0", cyc); end
    checks++; if (b0.return_val !== 32'd0) begin errs++; $display("FAIL len0_ret got %0d want 0", b0.return_val); end
    run(8, cyc, bok);
    r8 = b0.return_val;
    checks++; if (r8 !== ref_dot(8)) begin errs++; $display("FAIL len8_ret got %h want %h", r8, ref_dot(8)); end
    run(15, cyc, bok);
    checks++; if (b0.return_val !== ref_dot(8)) begin errs++; $display("FAIL len15_ret got %h want %h", b0.return_val, ref_dot(8)); end
    checks++; if (cyc !== 32) begin errs++; $display("FAIL len15_latency got %0d want 32", cyc); end
  endtask

  task automatic test_reset_mid();
    int cyc; bit bok;
    fill_rand();
    b0.start = 1'b1; b0.len = 4'd8;
    @(posedge clk); #1;
    b0.start = 1'b0;
    repeat (3 * (L0 + 2) + 2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (b0.finished !== 1'b0) begin errs++; $display("FAIL midrst_finished got %0b want 0", b0.finished); end
    checks++; if (b0.return_val !== 32'd0) begin errs++; $display("FAIL midrst_ret got %0d want 0", b0.return_val); end
    checks++; if (b0.busy !== 1'b0) begin errs++; $display("FAIL midrst_busy got %0b want 0", b0.busy); end
    reset = 1'b0;
    @(posedge clk); #1;
    run(8, cyc, bok);
    checks++; if (b0.return_val !== ref_dot(8)) begin errs++; $display("FAIL midrst_rerun got %h want %h", b0.return_val, ref_dot(8)); end
  endtask

  task automatic test_busy_ignore();
    int cyc; bit bok; logic [31:0] exp;
    fill_rand();
    exp = ref_dot(8);
    b0.start = 1'b1; b0.len = 4'd8;
    @(posedge clk); #1;
    b0.start = 1'b0;
    cyc = 0; bok = 1'b1;
    while (!b0.finished && cyc < 500) begin
      if (!b0.busy) bok = 1'b0;
      if (cyc == 5 || cyc == 14) begin
        b0.start = 1'b1; b0.len = 4'd1;
        b0.wr_en = 1'b1; b0.wr_sel = cyc[0]; b0.wr_addr = 3'd0; b0.wr_data = ~mx[0];
      end else begin
        b0.start = 1'b0; b0.wr_en = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    b0.start = 1'b0; b0.wr_en = 1'b0;
    checks++; if (b0.return_val !== exp) begin errs++; $display("FAIL busy_ret got %h want %h", b0.return_val, exp); end
    checks++; if (cyc !== 32) begin errs++; $display("FAIL busy_latency got %0d want 32", cyc); end
    checks++; if (bok !== 1'b1) begin errs++; $display("FAIL busy_level got dropped want held"); end
    run(8, cyc, bok);
    checks++; if (b0.return_val !== exp) begin errs++; $display("FAIL busy_mem got %h want %h", b0.return_val, exp); end
  endtask

  task automatic test_wr_start();
    int cyc; bit bok; logic [31:0] exp_old;
    fill_rand();
    exp_old = ref_dot(8);
    b0.start = 1'b1; b0.len = 4'd8;
    b0.wr_en = 1'b1; b0.wr_sel = 1'b1; b0.wr_addr = 3'd2; b0.wr_data = $urandom;
    @(posedge clk); #1;
    my[2] = b0.wr_data;
    b0.start = 1'b0; b0.wr_en = 1'b0;
    cyc = 0;
    while (!b0.finished && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (b0.return_val !== exp_old) begin errs++; $display("FAIL wrstart_old got %h want %h", b0.return_val, exp_old); end
    run(8, cyc, bok);
    checks++; if (b0.return_val !== ref_dot(8)) begin errs++; $display("FAIL wrstart_new got %h want %h", b0.return_val, ref_dot(8)); end
  endtask

  task automatic test_width8();
    int cyc;
    nx[0] = 8'd200; ny[0] = 8'd200;
    for (int i = 1; i < 4; i++) begin nx[i] = 8'($urandom); ny[i] = 8'($urandom); end
    for (int i = 0; i < 8; i++) begin
      b1.wr_en = 1'b1; b1.wr_sel = i[0]; b1.wr_addr = 2'(i / 2);
      b1.wr_data = i[0] ? ny[i/2] : nx[i/2];
      @(posedge clk); #1;
    end
    b1.wr_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      b1.start = 1'b1; b1.len = (k == 0) ? 3'd1 : 3'd7;
      @(posedge clk); #1;
      b1.start = 1'b0;
      cyc = 0;
      while (!b1.finished && cyc < 500) begin
        @(posedge clk); #1;
        cyc++;
      end
      if (k == 0) begin
        checks++; if (b1.return_val !== 8'd64) begin errs++; $display("FAIL w8_trunc got %0d want 64", b1.return_val); end
        checks++; if (cyc !== L1 + 2) begin errs++; $display("FAIL w8_latency got %0d want %0d", cyc, L1 + 2); end
      end else begin
        checks++; if (b1.return_val !== ref_dot8(7)) begin errs++; $display("FAIL w8_clamp got %0d want %0d", b1.return_val, ref_dot8(7)); end
        checks++; if (cyc !== 4 * (L1 + 2)) begin errs++; $display("FAIL w8_clamp_latency got %0d want %0d", cyc, 4 * (L1 + 2)); end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    b0.start = 1'b0; b0.len = '0; b0.wr_en = 1'b0; b0.wr_sel = 1'b0; b0.wr_addr = '0; b0.wr_data = '0;
    b1.start = 1'b0; b1.len = '0; b1.wr_en = 1'b0; b1.wr_sel = 1'b0; b1.wr_addr = '0; b1.wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_ramp();
    test_random();
    test_len_edge();
    test_reset_mid();
    test_busy_ignore();
    test_wr_start();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
